// File: rtl/ai_coef_writer.sv
// ai_coef_writer
//   Packs a byte stream, little-endian, into 32-bit words and writes them into the
//   coefficient RAM (c_ram) at sequential word addresses.
//   The number of words follows the reader's addressing rule:
//     compress=1 -> sample_size+1 words
//     compress=0 -> (sample_size>>1)+1 words (two samples share one word)
//   While a write is pending, incoming bytes keep packing. This gives one word of
//   buffering. A further word that completes before the pending one is accepted is
//   dropped, and the sticky overflow flag is set.
//
// Optional feature (macro AI_COEF_WRITER_CHECKSUM_EN):
//   checksum is the mod-256 sum of every byte accepted since the last init.
//   When the macro is undefined, checksum is tied to 0.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   init          one-cycle pulse that starts or restarts a download
//                 (compress and sample_size are sampled here)
//   stream_in     incoming byte
//   stream_rdy    stream_in is valid this cycle
//   c_ram_addr    write word address (BASE_ADDR + word index)
//   c_ram_write   write request, held until c_ram_rdy
//   c_ram_wdata   write data; byte0 in [7:0], byte3 in [31:24]
//   c_ram_rdy     write accepted this cycle
//   busy          high in FILL or WRITE
//   done          one-cycle pulse after the last word is accepted
//   overflow      sticky; a word was dropped
//   checksum      see optional feature
module ai_coef_writer #(
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              compress,
  input  logic [14:0]       sample_size,
  input  logic [7:0]        stream_in,
  input  logic              stream_rdy,
  output logic [ADDR_W-1:0] c_ram_addr,
  output logic              c_ram_write,
  output logic [31:0]       c_ram_wdata,
  input  logic              c_ram_rdy,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [7:0]        checksum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [1:0]  byte_idx;
  logic [23:0] pack;       // lanes 0..2; lane 3 goes straight into the word register
  logic [15:0] word_idx;
  logic [15:0] w_total;

  logic        pending, last_pend, byte_ok, word_cpl, acked, finish, drop, load;
  logic [15:0] load_idx;

  always_comb begin
    pending   = (state == S_WRITE);
    // Once the last word is waiting to be written, every later byte is surplus.
    last_pend = pending && ((word_idx + 16'd1) == w_total);
    byte_ok   = stream_rdy && !init && (state == S_FILL || pending) && !last_pend;
    word_cpl  = byte_ok && (byte_idx == 2'd3);
    acked     = pending && c_ram_rdy;
    finish    = acked && ((word_idx + 16'd1) == w_total);
    drop      = word_cpl && pending && !c_ram_rdy;
    load      = word_cpl && !drop;
    // A word that completes while the previous word is accepted in the same cycle
    // takes the next address.
    load_idx  = word_idx + {15'd0, acked};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_IDLE;
      S_FILL:  if (load) state_nxt = S_WRITE;
      S_WRITE: if (finish) state_nxt = S_DONE;
               else if (acked && !load) state_nxt = S_FILL;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (init) state_nxt = S_FILL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      byte_idx    <= 2'd0;
      pack        <= 24'd0;
      word_idx    <= 16'd0;
      w_total     <= 16'd0;
      c_ram_addr  <= '0;
      c_ram_wdata <= 32'd0;
      c_ram_write <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      c_ram_write <= (state_nxt == S_WRITE);
      busy        <= (state_nxt == S_FILL) || (state_nxt == S_WRITE);
      done        <= (state_nxt == S_DONE);
      if (init) begin
        byte_idx <= 2'd0;
        pack     <= 24'd0;
        word_idx <= 16'd0;
        overflow <= 1'b0;
        w_total  <= compress ? ({1'b0, sample_size} + 16'd1)
                             : ({2'b0, sample_size[14:1]} + 16'd1);
      end else begin
        if (byte_ok) begin
          byte_idx <= byte_idx + 2'd1;
          case (byte_idx)
            2'd0:    pack[7:0]   <= stream_in;
            2'd1:    pack[15:8]  <= stream_in;
            2'd2:    pack[23:16] <= stream_in;
            default: ;
          endcase
        end
        if (acked) word_idx <= word_idx + 16'd1;
        if (load) begin
          c_ram_wdata <= {stream_in, pack};
          c_ram_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(load_idx);
        end
        if (drop) overflow <= 1'b1;
      end
    end
  end

`ifdef AI_COEF_WRITER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          checksum <= 8'd0;
    else if (init)    checksum <= 8'd0;
    else if (byte_ok) checksum <= checksum + stream_in;
  end
`else
  assign checksum = 8'd0;
`endif

endmodule

// File: tb/tb_ai_coef_writer.sv
module tb_ai_coef_writer;
  localparam int BASE = 'h100;

  logic        clk, rst, init, compress, stream_rdy, c_ram_rdy;
  logic [14:0] sample_size;
  logic [7:0]  stream_in;
  logic [15:0] c_ram_addr;
  logic [31:0] c_ram_wdata;
  logic        c_ram_write, busy, done, overflow;
  logic [7:0]  checksum;

  ai_coef_writer #(.BASE_ADDR(BASE), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .init(init), .compress(compress), .sample_size(sample_size),
    .stream_in(stream_in), .stream_rdy(stream_rdy), .c_ram_addr(c_ram_addr),
    .c_ram_write(c_ram_write), .c_ram_wdata(c_ram_wdata), .c_ram_rdy(c_ram_rdy),
    .busy(busy), .done(done), .overflow(overflow), .checksum(checksum));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a list of collected bytes, a queue of pending
  // words (at most one), and counts of written words.
  bit          m_act, m_done, m_ovf;
  logic [7:0]  m_cs;
  int          m_wr, m_W;
  logic [7:0]  bq[$];
  int          pa[$];
  logic [31:0] pd[$];
  bit          has, take, last, nw;
  logic [31:0] w;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_done = 0; m_ovf = 0; m_cs = 0; m_wr = 0; m_W = 0;
      bq.delete(); pa.delete(); pd.delete();
    end else begin
      m_done = 0;
      if (init) begin
        m_act = 1; m_ovf = 0; m_cs = 0; m_wr = 0;
        bq.delete(); pa.delete(); pd.delete();
        m_W = compress ? int'(sample_size) + 1 : int'(sample_size) / 2 + 1;
      end else if (m_act) begin
        has = pa.size() > 0;
        take = has && c_ram_rdy;
        last = has && (m_wr == m_W - 1);
        nw = 0;
        if (stream_rdy && !last) begin
          m_cs += stream_in;
          bq.push_back(stream_in);
          if (bq.size() == 4) begin
            w = {bq[3], bq[2], bq[1], bq[0]};
            bq.delete();
            if (has && !c_ram_rdy) m_ovf = 1;
            else nw = 1;
          end
        end
        if (take) begin
          void'(pa.pop_front()); void'(pd.pop_front());
          m_wr++;
          if (m_wr == m_W) begin m_act = 0; m_done = 1; end
        end
        if (nw) begin pa.push_back(BASE + m_wr); pd.push_back(w); end
      end
    end
  end

  // Per-cycle compare against the model.
  bit chk_en = 0;
  always @(negedge clk) if (chk_en) begin
    chk("write", {31'd0, c_ram_write}, {31'd0, pa.size() > 0});
    chk("busy", {31'd0, busy}, {31'd0, m_act});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef AI_COEF_WRITER_CHECKSUM_EN
    chk("checksum", {24'd0, checksum}, {24'd0, m_cs});
`else
    chk("checksum", {24'd0, checksum}, 32'd0);
`endif
    if (pa.size() > 0) begin
      chk("addr", {16'd0, c_ram_addr}, 32'(pa[0] & 'hFFFF));
      chk("wdata", c_ram_wdata, pd[0]);
    end
  end

  // Ready responder: 0 = ack every write at once, 1 = never, 2 = random,
  // 3 = random regardless of write.
  int rdy_mode = 0;
  always @(negedge clk) begin
    case (rdy_mode)
      0:       c_ram_rdy = c_ram_write;
      1:       c_ram_rdy = 1'b0;
      2:       c_ram_rdy = c_ram_write && ($urandom_range(1, 0) == 1);
      default: c_ram_rdy = ($urandom_range(1, 0) == 1);
    endcase
  end

  int          cap_addr[$];
  logic [31:0] cap_data[$];
  int          done_cnt = 0;
  always @(posedge clk) begin
    if (!rst && c_ram_write && c_ram_rdy) begin
      cap_addr.push_back(int'(c_ram_addr)); cap_data.push_back(c_ram_wdata);
    end
    if (!rst && done) done_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_init(input logic c, input logic [14:0] s);
    init = 1; compress = c; sample_size = s;
    tick();
    init = 0;
  endtask

  task automatic send(input logic [7:0] b);
    stream_in = b; stream_rdy = 1;
    tick();
    stream_rdy = 0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((busy || c_ram_write) && n < maxc) begin tick(); n++; end
    if (busy || c_ram_write) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic clear_log();
    cap_addr.delete(); cap_data.delete(); done_cnt = 0;
  endtask

  logic [31:0] exp1 [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

  initial begin
    rst = 1; init = 0; compress = 0; sample_size = 0; stream_in = 0; stream_rdy = 0;
    c_ram_rdy = 0;
    tick(2);
    chk("rst_write", {31'd0, c_ram_write}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", {16'd0, c_ram_addr}, 32'd0);
    rst = 0;
    chk_en = 1;
    tick();

    // Reset while a write is stalled.
    rdy_mode = 1;
    do_init(1, 3);
    for (int i = 0; i < 4; i++) send(8'(i + 8'h40));
    tick(2);
    chk("pre_rst_write", {31'd0, c_ram_write}, 32'd1);
    #2 rst = 1;
    #1;
    chk("arst_write", {31'd0, c_ram_write}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    tick();
    #2 rst = 0;
    tick();
    for (int i = 0; i < 5; i++) send(8'hEE);
    tick();
    chk("post_rst_idle", {31'd0, busy | c_ram_write}, 32'd0);

    // Basic compress download.
    rdy_mode = 0;
    clear_log();
    do_init(1, 3);
    for (int i = 0; i < 16; i++) send(8'(i));
    wait_idle(50);
    tick(2);
    chk("t1_count", 32'(cap_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < cap_addr.size(); i++) begin
      chk("t1_addr", 32'(cap_addr[i]), 32'(BASE + i));
      chk("t1_data", cap_data[i], exp1[i]);
    end
    chk("t1_done_pulses", 32'(done_cnt), 32'd1);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);

    // Uncompressed: sample_size=5 -> 3 words, 13th byte surplus.
    clear_log();
    do_init(0, 5);
    for (int i = 0; i < 13; i++) send(8'(8'h20 + i));
    wait_idle(50);
    tick(2);
    chk("t2_count", 32'(cap_addr.size()), 32'd3);
    if (cap_addr.size() == 3) begin
      chk("t2_addr_last", 32'(cap_addr[2]), 32'(BASE + 2));
      chk("t2_data_last", cap_data[2], 32'h2B2A2928);
    end

    // Overflow: rdy held low while 8 bytes stream in.
    clear_log();
    rdy_mode = 1;
    do_init(1, 7);
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
    tick(2);
    chk("t3_ovf", {31'd0, overflow}, 32'd1);
    chk("t3_hold_data", c_ram_wdata, 32'h13121110);
    chk("t3_hold_addr", {16'd0, c_ram_addr}, 32'(BASE));
    rdy_mode = 0;
    tick(4);
    chk("t3_count", 32'(cap_addr.size()), 32'd1);
    chk("t3_still_busy", {31'd0, busy}, 32'd1);

    // Partial word discarded by re-init.
    clear_log();
    do_init(1, 3);
    send(8'h11); send(8'h22);
    do_init(1, 3);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    tick(3);
    chk("t4_count", 32'(cap_addr.size()), 32'd1);
    if (cap_addr.size() == 1) begin
      chk("t4_addr", 32'(cap_addr[0]), 32'(BASE));
      chk("t4_data", cap_data[0], 32'hDDCCBBAA);
    end

    // Checksum wrap.
    do_init(1, 3);
    send(8'hFF); send(8'h01); send(8'h80);
`ifdef AI_COEF_WRITER_CHECKSUM_EN
    chk("t5_cs_partial", {24'd0, checksum}, 32'h80);
`else
    chk("t5_cs_partial", {24'd0, checksum}, 32'h0);
`endif
    send(8'h80);
    chk("t5_cs_wrap", {24'd0, checksum}, 32'h0);

    // Random traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      if (it % 60 == 0) rdy_mode = $urandom_range(3, 0);
      init = ($urandom_range(99, 0) < 2);
      compress = $urandom_range(1, 0);
      sample_size = 15'($urandom_range(9, 0));
      stream_rdy = ($urandom_range(99, 0) < 70);
      stream_in = 8'($urandom);
      tick();
    end
    init = 0; stream_rdy = 0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
